// File: rtl/rom_burst_reader.sv
// rom_burst_reader: arithmetic-sequence table streamed out as bursts over a registered valid/ready port.
// Addresses wrap at 2**ADDR_W; bursts longer than the table repeat words.
module rom_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int INIT_BASE = 1,
    parameter int INIT_STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   burst_len,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LEN_TWO = (ADDR_W+1)'(2);

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [ADDR_W:0]   r_rem, w_rem;
    logic [DATA_W-1:0] r_data, w_data;
    logic              r_valid, w_valid, r_last, w_last, r_busy, w_busy, r_done, w_done;

    // Table contents are computed rather than stored; wrap at DATA_W is intended.
    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return DATA_W'(INIT_BASE) + DATA_W'(INIT_STEP) * DATA_W'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_rem   <= w_rem;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_last  <= w_last;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_rem   = r_rem;
        w_data  = r_data;
        w_valid = r_valid;
        w_last  = r_last;
        w_busy  = r_busy;
        w_done  = 1'b0;
        if (r_state == IDLE) begin
            // abort in IDLE suppresses a coincident start
            if (start && !abort && burst_len != '0) begin
                w_addr  = start_addr + 1'b1;
                w_data  = rom(start_addr);
                w_rem   = burst_len;
                w_valid = 1'b1;
                w_last  = (burst_len == LEN_ONE);
                w_busy  = 1'b1;
                w_state = STREAM;
            end
        end else if (abort) begin
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_busy  = 1'b0;
            w_state = IDLE;
        end else if (r_valid && out_ready) begin
            if (r_rem > LEN_ONE) begin
                w_data = rom(r_addr);
                w_addr = r_addr + 1'b1;
                w_rem  = r_rem - 1'b1;
                w_last = (r_rem == LEN_TWO);
            end else begin
                w_valid = 1'b0;
                w_last  = 1'b0;
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = IDLE;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Parametrised read-only table with a built-in burst sequencer. Contents are an arithmetic sequence fixed at elaboration: mem[i] = INIT_BASE + INIT_STEP*i, truncated to DATA_W. A single start command streams burst_len consecutive words out of a registered valid/ready port. Addresses wrap modulo DEPTH. Sits between control logic and any datapath consumer that needs table constants streamed rather than randomly addressed.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (derived, not overridable)
INIT_BASE, 1, value of mem[0]
INIT_STEP, 2, increment between consecutive words (mod 2**DATA_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only when busy=0
start_addr  in  ADDR_W  first word address of burst
burst_len  in  ADDR_W+1  number of words, 0..2*DEPTH-1
abort  in  1  synchronous burst cancel
out_data  out  DATA_W  current word (registered)
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts word when out_valid & out_ready
out_last  out  1  qualifies final word of burst; meaningful only with out_valid
busy  out  1  burst in progress
done  out  1  one-cycle pulse after final word accepted

Behaviour:
- Reset (rst_n=0, async): out_data=0, out_valid=0, out_last=0, busy=0, done=0, internal addr=0, remaining=0, state=IDLE. Reset mid-burst discards the burst entirely; no done.
- States: IDLE, STREAM.
- IDLE: done is driven 0 except for its single pulse cycle. On an edge with start=1 and burst_len!=0, latch the command and load the first word:
  - addr <= start_addr+1, out_data <= mem[start_addr], remaining <= burst_len.
  - out_valid <= 1, out_last <= (burst_len==1), busy <= 1, go to STREAM.
  - Latency: start edge T, so first word is valid in cycle T+1.
- start with burst_len=0: ignored. No busy, no valid, no done.
- STREAM, handshake (out_valid & out_ready) at an edge:
  - If remaining>1: out_data <= mem[addr], addr <= addr+1 (mod DEPTH), remaining--, out_last <= (remaining==2).
  - Else (final word): out_valid<=0, out_last<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE.
- Throughput is 1 word/cycle with out_ready held high.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_last, addr and remaining hold. out_valid is never dropped without a handshake, except on abort or reset.
- start while busy=1: ignored, no queuing.
- A start in the same cycle as the done pulse is accepted, because busy is already 0.
- abort=1 at an edge in STREAM: out_valid<=0, out_last<=0, busy<=0, go to IDLE, no done. Abort takes priority over a simultaneous handshake. abort in IDLE has no effect and also blocks a simultaneous start.
- Wrap-around: addr increments modulo DEPTH. burst_len>DEPTH repeats words.
- Arithmetic: table values are computed at DATA_W bits and wrap silently. out_data keeps its last value when out_valid=0; it is not cleared.

Test Plan:
- Reset: assert rst_n=0 asynchronously between clock edges -> all outputs 0 immediately; release, idle 5 cycles -> out_valid=0, done=0.
- Basic burst: start_addr=0, burst_len=4, out_ready=1 -> out_data 1,3,5,7 on cycles T+1..T+4; out_last only with 7; done high for exactly one cycle at T+5; busy low from T+5.
- Wrap: start_addr=14, burst_len=4 -> 29,31,1,3. Separately, burst_len=17 from addr 0 -> 1..31 then 1, last on the 17th word.
- Backpressure: start_addr=2, burst_len=3, drop out_ready for 3 cycles after the first word -> out_data holds 5 with out_valid=1 throughout; sequence 5,7,9 delivered with no loss or duplication.
- Ignored commands: burst_len=0 -> no activity. Pulse start with start_addr=8 mid-burst -> current burst unaffected, no second burst. start on the done cycle -> new burst begins the next cycle.
- Abort/reset mid-burst: abort after the 2nd word of an 8-word burst -> out_valid=0 next cycle, done never asserts. Repeat with rst_n=0 in place of abort -> same, and all outputs are 0.
